// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous-read instruction memory.
// Fetch (F) has fixed priority; the loader (L) is forced through after STARVE_LIMIT denied cycles.
module imem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_err,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            dbg_owner,
  output logic [3:0]            dbg_starve_cnt
);

  // Handshake: a request is accepted at the rising edge where x_req && x_gnt;
  // requesters hold req/addr/we/wdata stable until then. The response (x_rvalid)
  // follows exactly one cycle after the accepting edge.

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_L    = 2'd2
  } owner_t;

  owner_t     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    l_gnt     = 1'b0;
    f_gnt     = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = l_wdata;
    owner_d   = OWN_NONE;
    err_d     = 1'b0;
    starve_d  = starve_q;

    // Grants are suppressed during reset so no access can slip through.
    if (!reset) begin
      l_gnt = l_req && (!f_req || (starve_q == LIMIT));
      f_gnt = f_req && !l_gnt;
    end

    if (l_gnt) begin
      mem_addr = {l_addr[ADDR_WIDTH-1:2], 2'b00};
      mem_we   = l_we;
      owner_d  = OWN_L;
    end else if (f_gnt) begin
      mem_addr = {f_addr[ADDR_WIDTH-1:2], 2'b00};
      owner_d  = OWN_F;
      err_d    = (f_addr[1:0] != 2'b00);
    end

    if (!l_req || l_gnt) begin
      starve_d = 4'd0;
    end else if (f_gnt && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  assign f_rvalid       = (owner_q == OWN_F);
  assign l_rvalid       = (owner_q == OWN_L);
  assign f_err          = err_q;
  assign f_rdata        = mem_rdata;
  assign l_rdata        = mem_rdata;
  assign dbg_owner      = owner_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios followed by constrained-random traffic,
// checked against a transaction-level model of grants, starvation and a word memory.
module tb_imem_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_owner;
  logic [3:0]  dbg_starve_cnt;

  imem_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .f_req         (f_req),
    .f_addr        (f_addr),
    .f_gnt         (f_gnt),
    .f_rvalid      (f_rvalid),
    .f_rdata       (f_rdata),
    .f_err         (f_err),
    .l_req         (l_req),
    .l_we          (l_we),
    .l_addr        (l_addr),
    .l_wdata       (l_wdata),
    .l_gnt         (l_gnt),
    .l_rvalid      (l_rvalid),
    .l_rdata       (l_rdata),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .dbg_owner     (dbg_owner),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory, 64 words, preloaded with 0x100 + index.
  logic [31:0] mem_arr [64];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h100 + 32'(i);
    end else begin
      if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= mem_arr[mem_addr[7:2]];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [64];
  int          cnt_m;
  logic        exp_fv, exp_lv, exp_err, exp_lw;
  logic [31:0] exp_data;
  logic        f_acc, l_acc, lg_seen;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h100 + 32'(i);
    cnt_m   = 0;
    exp_fv  = 1'b0;
    exp_lv  = 1'b0;
    exp_err = 1'b0;
    exp_lw  = 1'b0;
    f_acc   = 1'b0;
    l_acc   = 1'b0;
  endtask

  // One clock of traffic. Entered 1 time unit after a rising edge with inputs driven;
  // checks the combinational grant/memory drive, then the registered responses.
  task automatic cycle();
    logic        eg_f, eg_l;
    logic [31:0] ea;
    #3;
    eg_l = l_req && (!f_req || cnt_m == LIMIT);
    eg_f = f_req && !eg_l;
    ea   = eg_l ? {l_addr[31:2], 2'b00} : (eg_f ? {f_addr[31:2], 2'b00} : 32'h0);
    lg_seen = l_gnt;
    chk("f_gnt", f_gnt, eg_f);
    chk("l_gnt", l_gnt, eg_l);
    chk("mem_addr", mem_addr, ea);
    chk("mem_we", mem_we, eg_l && l_we);
    chk("starve_cnt", dbg_starve_cnt, cnt_m);
    if (eg_l && l_we) chk("mem_wdata", mem_wdata, l_wdata);

    exp_fv  = eg_f;
    exp_lv  = eg_l;
    exp_lw  = eg_l && l_we;
    exp_err = eg_f && (f_addr[1:0] != 2'b00);
    if (eg_f) exp_data = ref_mem[f_addr[7:2]];
    else if (eg_l) begin
      exp_data = ref_mem[l_addr[7:2]];
      if (l_we) ref_mem[l_addr[7:2]] = l_wdata;
    end
    if (!l_req || eg_l) cnt_m = 0;
    else if (eg_f && cnt_m < LIMIT) cnt_m = cnt_m + 1;
    f_acc = eg_f;
    l_acc = eg_l;

    @(posedge clk);
    #1;
    chk("f_rvalid", f_rvalid, exp_fv);
    chk("l_rvalid", l_rvalid, exp_lv);
    chk("f_err", f_err, exp_err);
    if (exp_fv) chk("f_rdata", f_rdata, exp_data);
    if (exp_lv && !exp_lw) chk("l_rdata", l_rdata, exp_data);
  endtask

  initial begin
    reset   = 1'b1;
    f_req   = 1'b1;
    f_addr  = 32'h0;
    l_req   = 1'b1;
    l_we    = 1'b1;
    l_addr  = 32'h0;
    l_wdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state with both requests high: nothing granted or written.
    chk("rst_f_gnt", f_gnt, 1'b0);
    chk("rst_l_gnt", l_gnt, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_f_rvalid", f_rvalid, 1'b0);
    chk("rst_l_rvalid", l_rvalid, 1'b0);
    chk("rst_f_err", f_err, 1'b0);
    chk("rst_starve", dbg_starve_cnt, 0);
    f_req  = 1'b0;
    l_req  = 1'b0;
    l_we   = 1'b0;
    reset  = 1'b0;

    // Idle
    cycle();
    cycle();

    // F only: six sequential fetches
    for (int i = 0; i < 6; i++) begin
      f_req  = 1'b1;
      f_addr = 32'(4 * i);
      cycle();
      chk("fonly_data", f_rdata, 32'h100 + 32'(i));
    end
    f_req = 1'b0;
    cycle();

    // L write, then F read of the same word
    l_req   = 1'b1;
    l_we    = 1'b1;
    l_addr  = 32'h8;
    l_wdata = 32'hDEADBEEF;
    cycle();
    chk("wr_ack", l_rvalid, 1'b1);
    l_req  = 1'b0;
    l_we   = 1'b0;
    f_req  = 1'b1;
    f_addr = 32'h8;
    cycle();
    chk("raw_data", f_rdata, 32'hDEADBEEF);
    f_req = 1'b0;
    cycle();

    // Starvation: both ports request continuously
    f_req  = 1'b1;
    f_addr = 32'h0;
    l_req  = 1'b1;
    l_we   = 1'b0;
    l_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("starve_pattern", lg_seen, (i % 5) == 4);
    end
    f_req = 1'b0;
    l_req = 1'b0;
    cycle();

    // Misaligned fetch, then an aligned one
    f_req  = 1'b1;
    f_addr = 32'h6;
    cycle();
    chk("mis_err", f_err, 1'b1);
    chk("mis_data", f_rdata, 32'h101);
    f_addr = 32'hC;
    cycle();
    chk("aligned_err", f_err, 1'b0);

    // Asynchronous reset mid-cycle with a misaligned F read in flight
    f_addr = 32'h12;
    cycle();
    l_req = 1'b1;
    l_we  = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_f_rvalid", f_rvalid, 1'b0);
    chk("mid_rst_l_rvalid", l_rvalid, 1'b0);
    chk("mid_rst_f_err", f_err, 1'b0);
    chk("mid_rst_f_gnt", f_gnt, 1'b0);
    chk("mid_rst_l_gnt", l_gnt, 1'b0);
    chk("mid_rst_mem_we", mem_we, 1'b0);
    f_req = 1'b0;
    l_req = 1'b0;
    l_we  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle();
    chk("post_rst_f_rvalid", f_rvalid, 1'b0);

    // Random traffic, honouring hold-until-granted
    for (int n = 0; n < 400; n++) begin
      if (!f_req || f_acc) begin
        f_req  = ($urandom_range(0, 3) != 0);
        f_addr = 32'($urandom_range(0, 255));
      end
      if (!l_req || l_acc) begin
        l_req   = ($urandom_range(0, 2) == 0);
        l_we    = $urandom_range(0, 1) == 1;
        l_addr  = 32'($urandom_range(0, 255));
        l_wdata = $urandom;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
